message_word_array: RTL and testbench
=====================================

Name: message_word_array

Overview:
- Parametrised successor to the single-word message receiver.
- Assembles a multi-word message payload from the byte stream delivered by a MsgRouter: NumWords words of BytesPerWord bytes each.
- Holds the payload in a working bank and commits it atomically to a read-side bank only when the message is complete.
- Exposes the committed bank through a registered read port, with completion, overflow and byte-count status.

Parameters:
BytesPerWord, 4, bytes per payload word; word width W = 8*BytesPerWord
NumWords, 4, words per message (>=1)
Default, 0, reset value of every word in both banks (W bits)

Ports:
Clock  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high; clears state and both banks to Default
ClearAddr  input  1  start-of-message strobe from MsgRouter
WriteByte  input  1  byte-valid strobe from MsgRouter
DataByte  input  8  payload byte, qualified by WriteByte
ReadAddr  input  $clog2(NumWords) (min 1)  committed-word select
ReadData  output  W  committed word at ReadAddr, registered
Complete  output  1  level; high once the current message is committed, cleared by ClearAddr/Reset
MsgDone  output  1  one-cycle pulse on the commit cycle
Overflow  output  1  sticky; a byte arrived after the payload was full
ByteCount  output  $clog2(NumWords*BytesPerWord+2)  bytes accepted since the last ClearAddr/Reset
ChecksumErr  output  1  present only with MSG_WORD_CHECKSUM_EN

Behaviour:
- Reset:
  - Both banks = Default; ReadData = Default after the next edge.
  - Byte lane = 0, word index = 0, ByteCount = 0.
  - Complete, MsgDone, Overflow and ChecksumErr = 0; state = COLLECT.
- Priority: Reset > ClearAddr > WriteByte.
  - ClearAddr and WriteByte in the same cycle: the byte is dropped.
- ClearAddr:
  - Lane, word index and ByteCount = 0; Complete, Overflow and ChecksumErr = 0; state = COLLECT.
  - The working bank keeps its contents and is overwritten byte by byte.
  - The committed bank is untouched.
- Byte order: little-endian within a word. The first byte of each word goes to bits [7:0], the next to [15:8], and so on. Words fill in index order 0..NumWords-1.
- State COLLECT, on WriteByte:
  - Write DataByte into the working word at the current lane; lane+1, ByteCount+1.
  - When the lane wraps, lane = 0 and word index +1.
  - On the last payload byte (edge N): state = COMMIT.
- State COMMIT (one cycle, the cycle after edge N), ending at edge N+1:
  - Copy the working bank to the committed bank.
  - MsgDone = 1 for one cycle; Complete = 1; state = DONE.
  - A WriteByte arriving during COMMIT is treated as overflow.
- State DONE, on WriteByte: Overflow = 1 (sticky). Both banks and ByteCount are unchanged. Leave DONE only via ClearAddr or Reset.
- ReadData latency: one cycle from ReadAddr, always sourced from the committed bank.
  - ReadAddr >= NumWords returns Default.
  - A read in the commit cycle returns the old value; the new value is visible from edge N+1 onwards.
- Reset mid-message: the partial data is discarded and the committed bank returns to Default.
- A partial message followed by ClearAddr leaves the committed bank unchanged.
- ByteCount saturates at its maximum and does not wrap.

Optional Feature:
MSG_WORD_CHECKSUM_EN
- Defined:
  - One extra checksum byte follows the payload. State CHECK sits between COLLECT and COMMIT.
  - The expected value is the 8-bit modulo-256 sum of all payload bytes, accumulated in COLLECT.
  - Match: proceed to COMMIT as normal.
  - Mismatch: no commit, no MsgDone; ChecksumErr = 1 and Complete = 1; state = DONE.
  - ByteCount includes the checksum byte.
- Undefined:
  - No CHECK state and no ChecksumErr port.
  - The commit follows the last payload byte directly.

Decomposition:
- Shared package msg_pkg:
  - state encoding COLLECT/CHECK/COMMIT/DONE
  - byte-width constant 8
  - function for lane/word index widths (clog2 with minimum 1)
- One natural sub-module, msg_checksum8: an 8-bit accumulator with clear/add/compare. Instantiated only under the macro.

Test Plan:
Common setup for all scenarios: BytesPerWord=2, NumWords=3, Default=0.
1. Reset for 2 cycles, then sweep ReadAddr 0..3 -> ReadData = 0x0000 each; Complete, MsgDone and Overflow = 0.
2. ClearAddr, then bytes 11 22 33 44 55 66 -> committed words 0x2211, 0x4433, 0x6655.
   - MsgDone high exactly one cycle, Complete = 1, ByteCount = 6.
   - ReadAddr=1 -> 0x4433 one cycle later.
3. After scenario 2, WriteByte 0x77 -> Overflow = 1 and stays high; all words unchanged.
   - ClearAddr -> Overflow = 0, Complete = 0, ByteCount = 0.
4. Partial message:
   - Send ClearAddr, then AA BB, then ClearAddr with WriteByte 0xCC in the same cycle -> 0xCC dropped, ByteCount = 0; committed bank still 0x2211/0x4433/0x6655.
   - Then send 01..06 -> 0x0201, 0x0403, 0x0605.
5. Reset after 3 of 6 bytes -> all ReadData = 0x0000, state COLLECT; a following full message commits correctly.
6. (macro defined) Payload 11..66, then checksum 0x65 -> commit, ChecksumErr = 0.
   - Repeat with checksum 0x64 -> ChecksumErr = 1, no MsgDone, committed bank unchanged.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the message word array: state encoding, byte width
// and the index-width helper used for lane, word and address counters.
package msg_pkg;

  localparam int ByteW = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    COMMIT  = 2'd2,
    DONE    = 2'd3
  } msgState_t;

  // clog2 that never collapses to a zero-width index
  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/message_word_array_if.sv
// MsgRouter-side byte stream plus read/status bus of the message word array.
// ChecksumErr exists only when MSG_WORD_CHECKSUM_EN is defined.
interface message_word_array_if #(
  parameter int BytesPerWord = 4,
  parameter int NumWords     = 4
);
  import msg_pkg::*;

  localparam int W      = ByteW * BytesPerWord;
  localparam int AddrW  = idxWidth(NumWords);
  localparam int CountW = $clog2(NumWords * BytesPerWord + 2);

  logic              ClearAddr;
  logic              WriteByte;
  logic [ByteW-1:0]  DataByte;
  logic [AddrW-1:0]  ReadAddr;
  logic [W-1:0]      ReadData;
  logic              Complete;
  logic              MsgDone;
  logic              Overflow;
  logic [CountW-1:0] ByteCount;
`ifdef MSG_WORD_CHECKSUM_EN
  logic              ChecksumErr;

  modport master (output ClearAddr, WriteByte, DataByte, ReadAddr,
                  input  ReadData, Complete, MsgDone, Overflow, ByteCount, ChecksumErr);
  modport slave  (input  ClearAddr, WriteByte, DataByte, ReadAddr,
                  output ReadData, Complete, MsgDone, Overflow, ByteCount, ChecksumErr);
`else
  modport master (output ClearAddr, WriteByte, DataByte, ReadAddr,
                  input  ReadData, Complete, MsgDone, Overflow, ByteCount);
  modport slave  (input  ClearAddr, WriteByte, DataByte, ReadAddr,
                  output ReadData, Complete, MsgDone, Overflow, ByteCount);
`endif

endinterface

// File: rtl/msg_checksum8.sv
// Modulo-256 byte accumulator with clear/add and compare against a received byte.
// Only compiled when MSG_WORD_CHECKSUM_EN is defined.
`ifdef MSG_WORD_CHECKSUM_EN
module msg_checksum8
  import msg_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Add,
  input  logic [ByteW-1:0] DataByte,
  input  logic [ByteW-1:0] CheckByte,
  output logic             Match
);

  logic [ByteW-1:0] sum;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      sum <= '0;
    end else if (Add) begin
      sum <= sum + DataByte;
    end
  end

  assign Match = (sum == CheckByte);

endmodule
`endif

// File: rtl/message_word_array.sv
// Assembles NumWords little-endian words from a byte stream, commits them atomically
// to a read bank. Optional trailing checksum byte with MSG_WORD_CHECKSUM_EN.
module message_word_array
  import msg_pkg::*;
#(
  parameter int                            BytesPerWord = 4,
  parameter int                            NumWords     = 4,
  parameter logic [ByteW*BytesPerWord-1:0] Default      = '0
) (
  input logic                 Clock,
  input logic                 Reset,
  message_word_array_if.slave Bus
);

  localparam int W      = ByteW * BytesPerWord;
  localparam int LaneW  = idxWidth(BytesPerWord);
  localparam int WordW  = idxWidth(NumWords);
  localparam int CountW = $clog2(NumWords * BytesPerWord + 2);

  msgState_t         state;
  logic [LaneW-1:0]  lane;
  logic [WordW-1:0]  wordIdx;
  logic [CountW-1:0] byteCount;
  logic [W-1:0]      workBank   [NumWords];
  logic [W-1:0]      commitBank [NumWords];
  logic [W-1:0]      readData;
  logic              complete;
  logic              msgDone;
  logic              overflow;
  logic              lastLane;
  logic              lastWord;

  function automatic logic [CountW-1:0] satInc(input logic [CountW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign lastLane = (lane == LaneW'(BytesPerWord - 1));
  assign lastWord = (wordIdx == WordW'(NumWords - 1));

`ifdef MSG_WORD_CHECKSUM_EN
  logic chkErr;
  logic chkMatch;
  logic acceptByte;

  assign acceptByte = (state == COLLECT) && Bus.WriteByte && !Bus.ClearAddr;

  msg_checksum8 uChecksum (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clear     (Bus.ClearAddr),
    .Add       (acceptByte),
    .DataByte  (Bus.DataByte),
    .CheckByte (Bus.DataByte),
    .Match     (chkMatch)
  );

  assign Bus.ChecksumErr = chkErr;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= COLLECT;
      lane      <= '0;
      wordIdx   <= '0;
      byteCount <= '0;
      complete  <= 1'b0;
      msgDone   <= 1'b0;
      overflow  <= 1'b0;
      readData  <= Default;
      for (int i = 0; i < NumWords; i++) begin
        workBank[i]   <= Default;
        commitBank[i] <= Default;
      end
`ifdef MSG_WORD_CHECKSUM_EN
      chkErr    <= 1'b0;
`endif
    end else begin
      msgDone  <= 1'b0;
      // Read port always sees the committed bank; a commit this cycle shows next cycle
      readData <= (int'(Bus.ReadAddr) < NumWords) ? commitBank[Bus.ReadAddr] : Default;

      if (Bus.ClearAddr) begin
        state     <= COLLECT;
        lane      <= '0;
        wordIdx   <= '0;
        byteCount <= '0;
        complete  <= 1'b0;
        overflow  <= 1'b0;
`ifdef MSG_WORD_CHECKSUM_EN
        chkErr    <= 1'b0;
`endif
      end else begin
        case (state)
          COLLECT: if (Bus.WriteByte) begin
            workBank[wordIdx][lane*ByteW +: ByteW] <= Bus.DataByte;
            byteCount <= satInc(byteCount);
            if (lastLane) begin
              lane <= '0;
              if (lastWord) begin
                wordIdx <= '0;
`ifdef MSG_WORD_CHECKSUM_EN
                state   <= CHECK;
`else
                state   <= COMMIT;
`endif
              end else begin
                wordIdx <= wordIdx + 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
`ifdef MSG_WORD_CHECKSUM_EN
          CHECK: if (Bus.WriteByte) begin
            byteCount <= satInc(byteCount);
            if (chkMatch) begin
              state <= COMMIT;
            end else begin
              chkErr   <= 1'b1;
              complete <= 1'b1;
              state    <= DONE;
            end
          end
`endif
          COMMIT: begin
            for (int i = 0; i < NumWords; i++) begin
              commitBank[i] <= workBank[i];
            end
            msgDone  <= 1'b1;
            complete <= 1'b1;
            state    <= DONE;
            if (Bus.WriteByte) overflow <= 1'b1;
          end
          DONE: if (Bus.WriteByte) overflow <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign Bus.ReadData  = readData;
  assign Bus.Complete  = complete;
  assign Bus.MsgDone   = msgDone;
  assign Bus.Overflow  = overflow;
  assign Bus.ByteCount = byteCount;

endmodule

// File: tb/tb_message_word_array.sv
// Scoreboard bench for message_word_array (BytesPerWord=2, NumWords=3, Default=0).
// Also covers the checksum scenarios when MSG_WORD_CHECKSUM_EN is defined.
module tb_message_word_array;

  localparam int BPW = 2;
  localparam int NW  = 3;
`ifdef MSG_WORD_CHECKSUM_EN
  localparam int BC  = 7;
`else
  localparam int BC  = 6;
`endif

  localparam int K_READ     = 0;
  localparam int K_COMPLETE = 1;
  localparam int K_MSGDONE  = 2;
  localparam int K_OVERFLOW = 3;
  localparam int K_COUNT    = 4;
  localparam int K_CHKERR   = 5;

  typedef struct {
    int          kind;
    logic [15:0] value;
    int          cyc;
  } chk_t;

  logic        Clock = 1'b0;
  logic        Reset;
  chk_t        sb[$];
  int          cycleCnt = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic [15:0] monAct;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cycleCnt++;

  message_word_array_if #(.BytesPerWord(BPW), .NumWords(NW)) bus ();

  message_word_array #(.BytesPerWord(BPW), .NumWords(NW), .Default(16'h0000)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Bus   (bus)
  );

  function automatic string kindName(input int k);
    case (k)
      K_READ:     return "ReadData";
      K_COMPLETE: return "Complete";
      K_MSGDONE:  return "MsgDone";
      K_OVERFLOW: return "Overflow";
      K_COUNT:    return "ByteCount";
      default:    return "ChecksumErr";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int k);
    case (k)
      K_READ:     return bus.ReadData;
      K_COMPLETE: return {15'd0, bus.Complete};
      K_MSGDONE:  return {15'd0, bus.MsgDone};
      K_OVERFLOW: return {15'd0, bus.Overflow};
      K_COUNT:    return 16'(bus.ByteCount);
`ifdef MSG_WORD_CHECKSUM_EN
      K_CHKERR:   return {15'd0, bus.ChecksumErr};
`endif
      default:    return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compares every scoreboard entry that falls due in the current cycle
  always @(negedge Clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cycleCnt) begin
        checks++;
        monAct = actual(sb[i].kind);
        if (monAct !== sb[i].value) begin
          errors++;
          $display("FAIL %s cycle=%0d actual=0x%h required=0x%h",
                   kindName(sb[i].kind), cycleCnt, monAct, sb[i].value);
        end
        sb.delete(i);
      end
    end
  end

  task automatic want(input int kind, input logic [15:0] v, input int delay);
    chk_t e;
    e.kind  = kind;
    e.value = v;
    e.cyc   = cycleCnt + delay;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.WriteByte = 1'b1;
    bus.DataByte  = b;
    step();
    bus.WriteByte = 1'b0;
  endtask

  task automatic clearAddr();
    bus.ClearAddr = 1'b1;
    step();
    bus.ClearAddr = 1'b0;
  endtask

  task automatic readWant(input logic [1:0] a, input logic [15:0] v);
    bus.ReadAddr = a;
    want(K_READ, v, 1);
    step();
  endtask

  task automatic readBank(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    readWant(2'd0, w0);
    readWant(2'd1, w1);
    readWant(2'd2, w2);
    readWant(2'd3, 16'h0000);
  endtask

  task automatic sendPayload(input logic [47:0] m);
    for (int i = 0; i < 6; i++) sendByte(m[8*i +: 8]);
  endtask

  // Called right after the edge that accepted the final byte of a good message
  task automatic commitChecks(input logic [15:0] old0);
    want(K_MSGDONE,  16'd0, 0);
    want(K_COMPLETE, 16'd0, 0);
    want(K_COUNT,    16'(BC), 0);
    want(K_MSGDONE,  16'd1, 1);
    want(K_COMPLETE, 16'd1, 1);
    want(K_MSGDONE,  16'd0, 2);
    readWant(2'd0, old0);
    idle(1);
  endtask

`ifdef MSG_WORD_CHECKSUM_EN
  function automatic logic [7:0] sum8(input logic [47:0] m);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 6; i++) s = s + m[8*i +: 8];
    return s;
  endfunction
`endif

  task automatic sendMsg(input logic [47:0] m, input logic [15:0] old0);
    sendPayload(m);
`ifdef MSG_WORD_CHECKSUM_EN
    sendByte(sum8(m));
    want(K_CHKERR, 16'd0, 0);
`endif
    commitChecks(old0);
  endtask

  initial begin
    Reset         = 1'b1;
    bus.ClearAddr = 1'b0;
    bus.WriteByte = 1'b0;
    bus.DataByte  = 8'h00;
    bus.ReadAddr  = 2'd0;

    // 1: reset state
    idle(2);
    Reset = 1'b0;
    want(K_COMPLETE, 16'd0, 0);
    want(K_MSGDONE,  16'd0, 0);
    want(K_OVERFLOW, 16'd0, 0);
    want(K_COUNT,    16'd0, 0);
`ifdef MSG_WORD_CHECKSUM_EN
    want(K_CHKERR,   16'd0, 0);
`endif
    readBank(16'h0000, 16'h0000, 16'h0000);

    // 2: full message
    clearAddr();
    sendMsg(48'h665544332211, 16'h0000);
    checks++;
    if (bus.Complete !== 1'b1) begin
      errors++;
      $display("FAIL Complete after commit actual=%b required=1", bus.Complete);
    end
    checks++;
    if (16'(bus.ByteCount) !== 16'(BC)) begin
      errors++;
      $display("FAIL ByteCount after commit actual=%0d required=%0d", bus.ByteCount, BC);
    end
    readBank(16'h2211, 16'h4433, 16'h6655);
    readWant(2'd1, 16'h4433);

    // 3: overflow after completion, then clear
    want(K_OVERFLOW, 16'd0, 0);
    sendByte(8'h77);
    want(K_OVERFLOW, 16'd1, 0);
    idle(2);
    want(K_OVERFLOW, 16'd1, 0);
    want(K_COUNT,    16'(BC), 0);
    want(K_COMPLETE, 16'd1, 0);
    readBank(16'h2211, 16'h4433, 16'h6655);
    clearAddr();
    want(K_OVERFLOW, 16'd0, 0);
    want(K_COMPLETE, 16'd0, 0);
    want(K_COUNT,    16'd0, 0);
    checks++;
    if (bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL Overflow after ClearAddr actual=%b required=0", bus.Overflow);
    end
    checks++;
    if (16'(bus.ByteCount) !== 16'd0) begin
      errors++;
      $display("FAIL ByteCount after ClearAddr actual=%0d required=0", bus.ByteCount);
    end

    // 4: partial message, clear colliding with a byte, then a fresh message
    clearAddr();
    sendByte(8'hAA);
    sendByte(8'hBB);
    want(K_COUNT, 16'd2, 0);
    bus.ClearAddr = 1'b1;
    sendByte(8'hCC);
    bus.ClearAddr = 1'b0;
    want(K_COUNT,    16'd0, 0);
    want(K_COMPLETE, 16'd0, 0);
    readBank(16'h2211, 16'h4433, 16'h6655);
    sendMsg(48'h060504030201, 16'h2211);
    readBank(16'h0201, 16'h0403, 16'h0605);

    // 5: reset mid-message
    clearAddr();
    sendByte(8'hA1);
    sendByte(8'hA2);
    sendByte(8'hA3);
    want(K_COUNT, 16'd3, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    want(K_COUNT,    16'd0, 0);
    want(K_COMPLETE, 16'd0, 0);
    checks++;
    if (16'(bus.ByteCount) !== 16'd0) begin
      errors++;
      $display("FAIL ByteCount after Reset actual=%0d required=0", bus.ByteCount);
    end
    readBank(16'h0000, 16'h0000, 16'h0000);
    sendMsg(48'h605040302010, 16'h0000);
    readBank(16'h2010, 16'h4030, 16'h6050);

`ifdef MSG_WORD_CHECKSUM_EN
    // 6a: good checksum
    clearAddr();
    sendPayload(48'h665544332211);
    sendByte(8'h65);
    want(K_CHKERR, 16'd0, 0);
    commitChecks(16'h2010);
    readBank(16'h2211, 16'h4433, 16'h6655);

    // 6b: bad checksum, same payload
    clearAddr();
    sendPayload(48'h665544332211);
    sendByte(8'h64);
    want(K_CHKERR,   16'd1, 0);
    want(K_COMPLETE, 16'd1, 0);
    want(K_COUNT,    16'd7, 0);
    want(K_MSGDONE,  16'd0, 0);
    want(K_MSGDONE,  16'd0, 1);
    want(K_MSGDONE,  16'd0, 2);
    idle(3);
    readBank(16'h2211, 16'h4433, 16'h6655);

    // 6c: bad checksum on a different payload must not commit it
    clearAddr();
    want(K_CHKERR, 16'd0, 0);
    sendPayload(48'h060504030201);
    sendByte(8'h64);
    want(K_CHKERR, 16'd1, 0);
    want(K_MSGDONE, 16'd0, 1);
    idle(3);
    readBank(16'h2211, 16'h4433, 16'h6655);
`endif

    idle(3);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (due cycle %0d) required=0x%h",
               kindName(sb[0].kind), sb[0].cyc, sb[0].value);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
